// File: rtl/filter_alloc_sched_if.sv
// Round-issue bus: layer controller start/config in, per-round filter map out under valid/ready.
interface filter_alloc_sched_if #(
   parameter int unsigned NUM_MACRO = 16,
   parameter int unsigned OUT_CH    = 512
);
   localparam int unsigned BIT_OUT_CH = $clog2(OUT_CH);
   localparam int unsigned BIT_M      = $clog2(NUM_MACRO);

   logic                            start;
   logic [BIT_OUT_CH:0]             cfg_num_filter;
   logic [BIT_M:0]                  cfg_split_log2;
   logic [NUM_MACRO*BIT_OUT_CH-1:0] WHICH_FILTER;
   logic [NUM_MACRO-1:0]            macro_en;
   logic                            out_valid;
   logic                            out_ready;
   logic                            out_last;
   logic                            busy;
   logic                            done;

   // Scheduler side.
   modport master (
      input  start, cfg_num_filter, cfg_split_log2, out_ready,
      output WHICH_FILTER, macro_en, out_valid, out_last, busy, done
   );

   // Controller / consumer side.
   modport slave (
      output start, cfg_num_filter, cfg_split_log2, out_ready,
      input  WHICH_FILTER, macro_en, out_valid, out_last, busy, done
   );
endinterface

// File: rtl/filter_alloc_sched.sv
// Schedules a layer's output-channel filters onto the macro array one round at a time.
// Each filter occupies 2^split adjacent macros; all outputs are registered.
module filter_alloc_sched #(
   parameter int unsigned NUM_MACRO = 16,
   parameter int unsigned OUT_CH    = 512
) (
   input  logic                 clk,
   input  logic                 rst_n,
   filter_alloc_sched_if.master sched_io
);
   localparam int unsigned BIT_OUT_CH = $clog2(OUT_CH);
   localparam int unsigned BIT_M      = $clog2(NUM_MACRO);
   // One extra bit so base + filters-per-round never wraps.
   localparam int unsigned SumW       = BIT_OUT_CH + 2;

   localparam logic [BIT_OUT_CH:0] MaxFilt  = (BIT_OUT_CH + 1)'(OUT_CH);
   localparam logic [BIT_M:0]      MaxSplit = (BIT_M + 1)'(BIT_M);

   typedef enum logic [1:0] {StIdle, StLoad, StIssue, StDone} state_e;

   state_e                          state_q, state_d;
   logic [BIT_OUT_CH:0]             num_q, num_d;
   logic [BIT_OUT_CH:0]             base_q, base_d;
   logic [BIT_M:0]                  split_q, split_d;
   logic [NUM_MACRO*BIT_OUT_CH-1:0] which_q, which_d;
   logic [NUM_MACRO-1:0]            en_q, en_d;
   logic                            valid_q, valid_d;
   logic                            last_q, last_d;
   logic                            busy_q, busy_d;
   logic                            done_q, done_d;
   logic                            load_round;
   logic [SumW-1:0]                 per_round;
   logic [SumW-1:0]                 filt;

   assign per_round = SumW'(NUM_MACRO) >> split_q;

   // Next-state, config latch and next round contents.
   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      split_d    = split_q;
      base_d     = base_q;
      which_d    = which_q;
      en_d       = en_q;
      valid_d    = valid_q;
      last_d     = last_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      load_round = 1'b0;
      filt       = '0;

      unique case (state_q)
         StIdle: begin
            if (sched_io.start) begin
               state_d = StLoad;
               busy_d  = 1'b1;
               num_d   = (sched_io.cfg_num_filter > MaxFilt) ? MaxFilt : sched_io.cfg_num_filter;
               split_d = (sched_io.cfg_split_log2 > MaxSplit) ? MaxSplit : sched_io.cfg_split_log2;
            end
         end
         StLoad: begin
            base_d = '0;
            if (num_q == '0) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else begin
               state_d    = StIssue;
               valid_d    = 1'b1;
               load_round = 1'b1;
            end
         end
         StIssue: begin
            if (valid_q && sched_io.out_ready) begin
               if (last_q) begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  which_d = '0;
                  en_d    = '0;
               end else begin
                  base_d     = base_q + per_round[BIT_OUT_CH:0];
                  load_round = 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
         default: state_d = StIdle;
      endcase

      // Macro m serves filter base + (m >> split); unused macros are masked and zeroed.
      if (load_round) begin
         which_d = '0;
         en_d    = '0;
         for (int unsigned m = 0; m < NUM_MACRO; m++) begin
            filt = SumW'(base_d) + (SumW'(m) >> split_q);
            if (filt < SumW'(num_q)) begin
               en_d[m]                             = 1'b1;
               which_d[m*BIT_OUT_CH +: BIT_OUT_CH] = filt[BIT_OUT_CH-1:0];
            end
         end
         last_d = (SumW'(base_d) + per_round) >= SumW'(num_q);
      end
   end

   // State and output registers; reset aborts any layer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         num_q   <= '0;
         split_q <= '0;
         base_q  <= '0;
         which_q <= '0;
         en_q    <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         split_q <= split_d;
         base_q  <= base_d;
         which_q <= which_d;
         en_q    <= en_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sched_io.WHICH_FILTER = which_q;
   assign sched_io.macro_en     = en_q;
   assign sched_io.out_valid    = valid_q;
   assign sched_io.out_last     = last_q;
   assign sched_io.busy         = busy_q;
   assign sched_io.done         = done_q;
endmodule
